// File: rtl/gb_timer.sv
// DMG timer block: DIV/TIMA/TMA/TAC registers on the CPU bus, with the
// falling-edge tick detector (including write-induced glitch ticks) and the
// overflow -> reload -> interrupt sequence. One clk is one CPU M-cycle.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        wr_en_i,
    output logic [7:0]  rdata_o,
    output logic        sel_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [13:0] sys_cnt;
    logic [7:0]  tima;
    logic [7:0]  tima_nxt;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic        prev_sig;
    logic        sig;
    logic        tick;
    logic        irq_nxt;
    logic [15:0] offset;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;

    // Pick the system-counter bit whose falling edge clocks TIMA.
    function automatic logic tap_bit(input logic [13:0] cnt, input logic [1:0] sel);
        logic b;
        case (sel)
            2'b00:   b = cnt[7];
            2'b01:   b = cnt[1];
            2'b10:   b = cnt[3];
            default: b = cnt[5];
        endcase
        return b;
    endfunction

    // Address decode: the offset from DIV selects one of four registers.
    assign offset  = addr_i - BASE_ADDR;
    assign sel_o   = (offset[15:2] == 14'd0);
    assign wr_div  = wr_en_i & sel_o & (offset[1:0] == 2'd0);
    assign wr_tima = wr_en_i & sel_o & (offset[1:0] == 2'd1);
    assign wr_tma  = wr_en_i & sel_o & (offset[1:0] == 2'd2);
    assign wr_tac  = wr_en_i & sel_o & (offset[1:0] == 2'd3);

    // Tick is a falling edge of the gated tap; a DIV reset or a TAC change
    // that drops the signal also counts, reproducing the DMG glitch.
    assign sig  = tac[2] & tap_bit(sys_cnt, tac[1:0]);
    assign tick = prev_sig & ~sig;

    // Combinational read mux; unmapped addresses float high.
    always_comb begin
        rdata_o = 8'hFF;
        if (sel_o) begin
            case (offset[1:0])
                2'd0:    rdata_o = sys_cnt[13:6];
                2'd1:    rdata_o = tima;
                2'd2:    rdata_o = tma;
                default: rdata_o = {5'b11111, tac};
            endcase
        end
    end

    // Next-state and TIMA/IRQ decisions for the overflow sequencer.
    always_comb begin
        state_nxt = state;
        tima_nxt  = tima;
        irq_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_tima) begin
                    tima_nxt = wdata_i;
                end else if (tick) begin
                    tima_nxt = tima + 8'd1;
                    if (tima == 8'hFF) state_nxt = OVF;
                end
            end
            OVF: begin
                // A CPU write to TIMA in the overflow cycle cancels the reload.
                if (wr_tima) begin
                    tima_nxt  = wdata_i;
                    state_nxt = IDLE;
                end else begin
                    tima_nxt  = tma;
                    irq_nxt   = 1'b1;
                    state_nxt = RELOAD;
                end
            end
            RELOAD: begin
                // TIMA writes are dropped here; a TMA write lands in both.
                state_nxt = IDLE;
                if (wr_tma) begin
                    tima_nxt = wdata_i;
                end else if (tick) begin
                    tima_nxt = tima + 8'd1;
                    if (tima == 8'hFF) state_nxt = OVF;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, timer registers, edge history and registered interrupt pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sys_cnt  <= '0;
            tima     <= '0;
            tma      <= '0;
            tac      <= '0;
            prev_sig <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            sys_cnt  <= wr_div ? 14'd0 : sys_cnt + 14'd1;
            tima     <= tima_nxt;
            prev_sig <= sig;
            irq_o    <= irq_nxt;
            if (wr_tma) tma <= wdata_i;
            if (wr_tac) tac <= wdata_i[2:0];
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: stimulus pushes expected bus responses into a
// scoreboard queue; a negedge monitor pops and compares them.
module tb_gb_timer;

    logic        clk;
    logic        reset;
    logic [15:0] addr_i;
    logic [7:0]  wdata_i;
    logic        wr_en_i;
    logic [7:0]  rdata_o;
    logic        sel_o;
    logic        irq_o;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       ci;
        logic       i;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    logic  chk_vld;
    logic  done;
    int    checks;
    int    errors;
    int    irq_pulses;
    logic  irq_prev;
    exp_t  e;
    string nm;

    gb_timer #(.BASE_ADDR(16'hFF04)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wr_en_i (wr_en_i),
        .rdata_o (rdata_o),
        .sel_o   (sel_o),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // One bus cycle: optional write, optional expected-response push.
    task automatic cyc(input logic [15:0] a, input logic wr, input logic [7:0] d,
                       input logic chk, input logic [7:0] ed, input logic es,
                       input logic ci, input logic ei, input string name);
        exp_t x;
        addr_i  = a;
        wdata_i = d;
        wr_en_i = wr;
        if (chk) begin
            x.d = ed; x.s = es; x.ci = ci; x.i = ei;
            eq.push_back(x);
            nq.push_back(name);
            chk_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
        chk_vld = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] ed, input logic ei, input string name);
        cyc(a, 1'b0, 8'h00, 1'b1, ed, 1'b1, 1'b1, ei, name);
    endtask

    task automatic rd_out(input logic [15:0] a, input string name);
        cyc(a, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, name);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(a, 1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "");
    endtask

    task automatic wrc(input logic [15:0] a, input logic [7:0] d, input logic [7:0] ed,
                       input logic ei, input string name);
        cyc(a, 1'b1, d, 1'b1, ed, 1'b1, 1'b1, ei, name);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "");
    endtask

    // Stimulus; comments give sys_cnt of the cycle about to run.
    initial begin
        reset   = 1'b0;
        addr_i  = 16'h0000;
        wdata_i = 8'h00;
        wr_en_i = 1'b0;
        chk_vld = 1'b0;
        done    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // cnt 0: reset values
        rd(16'hFF04, 8'h00, 1'b0, "rst_div");
        rd(16'hFF05, 8'h00, 1'b0, "rst_tima");
        rd(16'hFF06, 8'h00, 1'b0, "rst_tma");
        rd(16'hFF07, 8'hF8, 1'b0, "rst_tac");
        rd_out(16'hFF08, "unmapped_ff08");

        // cnt 5: DIV steps at 64
        idle(58);
        rd(16'hFF04, 8'h00, 1'b0, "div_cnt63");
        rd(16'hFF04, 8'h01, 1'b0, "div_cnt64");
        wr(16'hFF04, 8'h5A);
        rd(16'hFF04, 8'h00, 1'b0, "div_after_wr");
        idle(62);
        rd(16'hFF04, 8'h00, 1'b0, "div_wr_cnt63");
        rd(16'hFF04, 8'h01, 1'b0, "div_wr_cnt64");

        // cnt 65: align, enable 4-clk tap, clear TIMA
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        idle(40);
        rd(16'hFF05, 8'h0A, 1'b0, "tima_run40");
        rd(16'hFF05, 8'h0A, 1'b0, "tima_c43");
        rd(16'hFF05, 8'h0A, 1'b0, "tima_c44");
        rd(16'hFF05, 8'h0B, 1'b0, "tima_c45");
        rd(16'hFF05, 8'h0B, 1'b0, "tima_c46");
        rd(16'hFF05, 8'h0B, 1'b0, "tima_c47");
        rd(16'hFF05, 8'h0B, 1'b0, "tima_c48");
        rd(16'hFF05, 8'h0C, 1'b0, "tima_c49");

        // cnt 50: overflow with reload from TMA=AB
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        rd(16'hFF05, 8'hFF, 1'b0, "ovf_pre");
        rd(16'hFF05, 8'h00, 1'b0, "ovf_zero");
        rd(16'hFF05, 8'hAB, 1'b1, "ovf_reload_irq");
        rd(16'hFF05, 8'hAB, 1'b0, "ovf_irq_drop");
        rd(16'hFF05, 8'hAB, 1'b0, "ovf_hold");
        rd(16'hFF05, 8'hAC, 1'b0, "ovf_next_tick");

        // cnt 58: TIMA write during OVF cancels reload and IRQ
        idle(1);
        wr(16'hFF05, 8'hFF);
        rd(16'hFF05, 8'hFF, 1'b0, "cancel_pre");
        wrc(16'hFF05, 8'h33, 8'h00, 1'b0, "cancel_ovf_cycle");
        rd(16'hFF05, 8'h33, 1'b0, "cancel_tima");
        rd(16'hFF05, 8'h33, 1'b0, "cancel_noirq1");
        rd(16'hFF05, 8'h33, 1'b0, "cancel_noirq2");
        rd(16'hFF05, 8'h34, 1'b0, "cancel_counts_on");

        // cnt 66: TMA write during RELOAD lands in TIMA
        idle(1);
        wr(16'hFF05, 8'hFF);
        rd(16'hFF05, 8'hFF, 1'b0, "tmawr_pre");
        rd(16'hFF05, 8'h00, 1'b0, "tmawr_ovf");
        wrc(16'hFF06, 8'h77, 8'hAB, 1'b1, "tmawr_reload_cycle");
        rd(16'hFF05, 8'h77, 1'b0, "tmawr_tima");
        rd(16'hFF05, 8'h77, 1'b0, "tmawr_hold");
        rd(16'hFF05, 8'h78, 1'b0, "tmawr_tick");
        rd(16'hFF06, 8'h77, 1'b0, "tmawr_tma");

        // cnt 75: TIMA write during RELOAD is ignored
        wr(16'hFF05, 8'hFF);
        rd(16'hFF05, 8'hFF, 1'b0, "timawr_pre");
        rd(16'hFF05, 8'h00, 1'b0, "timawr_ovf");
        wrc(16'hFF05, 8'h11, 8'h77, 1'b1, "timawr_reload_cycle");
        rd(16'hFF05, 8'h77, 1'b0, "timawr_ignored");
        rd(16'hFF05, 8'h77, 1'b0, "timawr_hold");
        rd(16'hFF05, 8'h78, 1'b0, "timawr_tick");

        // cnt 82 (bit1=1): DIV write glitch tick
        wr(16'hFF04, 8'h00);
        rd(16'hFF05, 8'h78, 1'b0, "glitch_div_pre");
        rd(16'hFF05, 8'h79, 1'b0, "glitch_div_inc");
        rd(16'hFF05, 8'h79, 1'b0, "glitch_div_c2");
        rd(16'hFF05, 8'h79, 1'b0, "glitch_div_c3");
        rd(16'hFF05, 8'h79, 1'b0, "glitch_div_c4");
        rd(16'hFF05, 8'h7A, 1'b0, "glitch_div_c5");
        // cnt 6 (bit1=1): disabling TAC also ticks
        wrc(16'hFF07, 8'h01, 8'hFD, 1'b0, "glitch_tac_cycle");
        rd(16'hFF05, 8'h7A, 1'b0, "glitch_tac_pre");
        rd(16'hFF05, 8'h7B, 1'b0, "glitch_tac_inc");
        rd(16'hFF07, 8'hF9, 1'b0, "tac_disabled");
        idle(8);
        rd(16'hFF05, 8'h7B, 1'b0, "disabled_frozen");

        // cnt 19: reset asserted in the RELOAD cycle
        wr(16'hFF07, 8'h05);
        idle(3);
        wr(16'hFF05, 8'hFF);
        rd(16'hFF05, 8'hFF, 1'b0, "rstmid_pre");
        rd(16'hFF05, 8'h00, 1'b0, "rstmid_ovf");
        reset = 1'b0;
        rd(16'hFF05, 8'h00, 1'b0, "rstmid_reload");
        reset = 1'b1;
        rd(16'hFF05, 8'h00, 1'b0, "rstmid_after1");
        rd(16'hFF04, 8'h00, 1'b0, "rstmid_div");
        rd(16'hFF07, 8'hF8, 1'b0, "rstmid_tac");
        rd(16'hFF06, 8'h00, 1'b0, "rstmid_tma");
        idle(4);
        rd(16'hFF05, 8'h00, 1'b0, "rstmid_after2");
        rd_out(16'hFF03, "unmapped_ff03");

        done = 1'b1;
    end

    // Scoreboard monitor: compares popped expectations, tracks IRQ pulses.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (eq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: queue empty, got no entry, required one entry");
            end else begin
                e  = eq.pop_front();
                nm = nq.pop_front();
                checks++;
                if (rdata_o !== e.d) begin
                    errors++;
                    $display("FAIL %s rdata: got %02h required %02h", nm, rdata_o, e.d);
                end
                checks++;
                if (sel_o !== e.s) begin
                    errors++;
                    $display("FAIL %s sel: got %b required %b", nm, sel_o, e.s);
                end
                if (e.ci) begin
                    checks++;
                    if (irq_o !== e.i) begin
                        errors++;
                        $display("FAIL %s irq: got %b required %b", nm, irq_o, e.i);
                    end
                end
            end
        end
        if (irq_o === 1'b1) begin
            checks++;
            if (irq_prev === 1'b1) begin
                errors++;
                $display("FAIL irq_width: got 2 consecutive high clk, required at most 1");
            end
            if (irq_prev !== 1'b1) irq_pulses++;
        end
        irq_prev = irq_o;
        if (done) begin
            checks++;
            if (eq.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d pending, required 0", eq.size());
            end
            checks++;
            if (irq_pulses != 3) begin
                errors++;
                $display("FAIL irq_pulse_count: got %0d required 3", irq_pulses);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        irq_pulses = 0;
        irq_prev   = 1'b0;
    end

endmodule

// File: doc/gb_timer.md
# gb_timer

Memory-mapped DMG timer (DIV/TIMA/TMA/TAC at FF04–FF07) that sits on the CPU data bus beside work RAM. It consumes CPU writes and returns read data. It raises a one-cycle timer interrupt request that the interrupt-flag logic ORs into FF0F bit 2, which feeds the CPU's `reg_IF` input. One `clk` equals one CPU M-cycle.

## Interface
- `BASE_ADDR`, default 16'hFF04: address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.
- `clk`  in  1: M-cycle clock. All state is rising-edge.
- `reset`  in  1: asynchronous, active-low reset. Asserting it clears all state immediately, including mid-operation.
- `addr_i`  in  16: CPU address bus (`addr_o` of the CPU).
- `wdata_i`  in  8: CPU write data (`data_o` of the CPU).
- `wr_en_i`  in  1: CPU write strobe (`drive_data_bus`).
- `rdata_o`  out  8: combinational read data for `addr_i`. Reads 8'hFF when `sel_o`=0.
- `sel_o`  out  1: combinational; high when `addr_i` is in BASE_ADDR..BASE_ADDR+3.
- `irq_o`  out  1: registered one-clk timer interrupt pulse.

## Operation
- State:
  - 14-bit `sys_cnt`
  - `tima[7:0]`, `tma[7:0]`, `tac[2:0]`
  - `prev_sig` register
  - 2-bit FSM {IDLE, OVF, RELOAD}
- Read values:
  - DIV = `sys_cnt[13:6]`
  - TIMA = `tima`
  - TMA = `tma`
  - TAC = {5'b11111, `tac`}
- `sys_cnt` increments by 1 every clk and wraps at 14 bits. A write to DIV (any data) sets it to 0 on that edge instead of incrementing.
- Tap select from `tac[1:0]`:
  - 00 → `sys_cnt[7]` (256 clk period)
  - 01 → bit 1 (4 clk)
  - 10 → bit 3 (16 clk)
  - 11 → bit 5 (64 clk)
- Tick generation:
  - `sig` = `tac[2]` & selected bit, evaluated on the current register values.
  - `prev_sig` <= `sig` each clk.
  - Tick = `prev_sig` & ~`sig`.
  - Falling edges caused by a DIV write or a TAC write (disable, or tap change) are real ticks. This is the DMG glitch and is required.
- On a tick, `tima` <= `tima`+1 (8-bit).
  - If `tima` was FF, it becomes 00 and the FSM enters OVF.
- FSM:
  - IDLE: normal counting.
  - OVF: lasts exactly one clk and `tima` reads 00. Exit to RELOAD, loading `tima` <= `tma` and setting `irq_o` <= 1.
  - OVF with a CPU write to TIMA in that clk: the write wins, the reload and IRQ are cancelled, and the FSM returns to IDLE.
  - RELOAD: lasts exactly one clk with `irq_o`=1. CPU writes to TIMA are ignored. A CPU write to TMA updates `tma` and also `tima` with the written value. Exit to IDLE.
  - Ticks during OVF/RELOAD increment `tima` normally, except when superseded by the reload or a write.
- Write priority on TIMA in IDLE: a CPU write beats a same-clk tick.
- TAC writes keep only `wdata_i[2:0]`.

## Timing
- Reset values: `sys_cnt`=0, `tima`=00, `tma`=00, `tac`=0 (reads F8), `prev_sig`=0, FSM=IDLE, `irq_o`=0.
- Writes take effect on the rising edge where `wr_en_i`=1. Reads are same-cycle combinational on register state.
- Tick latency: when the selected bit falls at an edge, `tima` increments on the following edge.
- Overflow sequence, with edge E being the tick edge where `tima` goes FF→00:
  - `tima`=00 for clk E..E+1.
  - At E+1, `tima`=TMA and `irq_o`=1 for exactly one clk.
  - At E+2, `irq_o`=0.
- `irq_o` never stays high for more than one consecutive clk.
- DIV increments every 64 clk. After reset, DIV reads 01 once `sys_cnt` reaches 64.
- Reset asserted during OVF/RELOAD: `irq_o` drops immediately, and no IRQ is emitted after release.

## Test plan
- Reset, then read FF04/FF05/FF06/FF07 → 00/00/00/F8, with `irq_o`=0 and `sel_o`=1. Read FF08 → FF with `sel_o`=0.
- Free-run 64 clk → DIV=01. Write 5A to FF04 → next read of DIV is 00, and DIV=01 again 64 clk later.
- Write TAC=05 and TIMA=00, then run 40 clk → TIMA=0A (±1 by phase). The increment interval measures exactly 4 clk.
- TMA=AB, TIMA=FF, TAC=05 → TIMA reads 00 for exactly 1 clk, then AB. `irq_o` is high exactly 1 clk, coincident with the first AB cycle.
- Same overflow setup, writing TIMA=33 during the 00 cycle → TIMA=33, `irq_o` never asserts. Separately, writing TMA=77 during the RELOAD cycle → TIMA=77, while a TIMA write in RELOAD is ignored.
- TAC=05 with `sys_cnt[1]`=1: write DIV → TIMA +1 one clk later. Write TAC=01 (disable) while `sys_cnt[1]`=1 → TIMA +1.
